// File: rtl/giraffe_pkg.sv
// Shared definitions for the ADC-to-UART frame packer: FSM encoding,
// default frame header and the running checksum update.
package giraffe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
   } state_t;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                              input logic [7:0] data);
      return csum ^ data;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_pop_s;
   logic             do_push_s;

   // A push into a full FIFO is legal when the same cycle pops a word.
   always_comb begin
      do_pop_s  = pop & ~empty;
      do_push_s = push & (~full | do_pop_s);
   end

   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign level = wr_ptr_r - rd_ptr_r;
   assign rdata = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage array; contents are only observed behind valid pointers.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/adc_uart_packer.sv
// Buffers ADC samples and emits them as UART frames: header byte,
// FRAME_LEN data bytes, then the XOR checksum of the data bytes.
module adc_uart_packer
   import giraffe_pkg::*;
#(
   parameter int         NUM_bit    = 6,
   parameter int         FIFO_DEPTH = 16,
   parameter int         FRAME_LEN  = 256,
   parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          sample_vld,
   input  logic [NUM_bit-1:0]            sample_data,
   input  logic                          uart_rdy,
   output logic                          uart_wreq,
   output logic [7:0]                    uart_wdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [15:0]                   frames_sent,
   output logic                          busy
);

   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

   state_t      state_r;
   state_t      state_s;
   logic [15:0] sample_cnt_r;
   logic [7:0]  csum_r;
   logic        wreq_r;
   logic [7:0]  wdata_r;
   logic        overflow_r;
   logic [15:0] frames_r;
   logic        busy_r;

   logic [7:0]  fifo_in_s;
   logic [7:0]  fifo_rdata_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic        push_req_s;
   logic        pop_s;
   logic        drop_s;
   logic        write_ok_s;
   logic        send_s;
   logic [7:0]  send_data_s;
   logic        clr_s;
   logic        frame_done_s;

   // Zero-extend the sample and qualify capture requests.
   always_comb begin
      fifo_in_s              = 8'h00;
      fifo_in_s[NUM_bit-1:0] = sample_data;
      push_req_s             = sample_vld & enable;
      drop_s                 = push_req_s & fifo_full_s & ~pop_s;
      // uart_rdy lags a write by one cycle, so the cycle after wreq is blanked.
      write_ok_s             = uart_rdy & ~wreq_r;
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req_s),
      .pop   (pop_s),
      .wdata (fifo_in_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level)
   );

   // Frame sequencing and byte selection.
   always_comb begin
      state_s      = state_r;
      pop_s        = 1'b0;
      send_s       = 1'b0;
      send_data_s  = 8'h00;
      clr_s        = 1'b0;
      frame_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable && !fifo_empty_s) begin
               state_s = ST_HEAD;
               clr_s   = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HEAD: begin
            if (write_ok_s) begin
               send_s      = 1'b1;
               send_data_s = HEADER;
               state_s     = ST_DATA;
            end else begin
               state_s = ST_HEAD;
            end
         end
         ST_DATA: begin
            if (write_ok_s && !fifo_empty_s) begin
               pop_s       = 1'b1;
               send_s      = 1'b1;
               send_data_s = fifo_rdata_s;
               if (sample_cnt_r == LAST_IDX) begin
                  state_s = ST_CSUM;
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_CSUM: begin
            if (write_ok_s) begin
               send_s       = 1'b1;
               send_data_s  = csum_r;
               frame_done_s = 1'b1;
               state_s      = ST_IDLE;
            end else begin
               state_s = ST_CSUM;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != ST_IDLE);
      end
   end

   // Per-frame sample counter and running checksum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt_r <= 16'd0;
         csum_r       <= 8'h00;
      end else if (clr_s) begin
         sample_cnt_r <= 16'd0;
         csum_r       <= 8'h00;
      end else if (pop_s) begin
         sample_cnt_r <= sample_cnt_r + 16'd1;
         csum_r       <= csum_update(csum_r, fifo_rdata_s);
      end
   end

   // UART write port; data holds its last value between requests.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wreq_r  <= 1'b0;
         wdata_r <= 8'h00;
      end else begin
         wreq_r <= send_s;
         if (send_s) begin
            wdata_r <= send_data_s;
         end
      end
   end

   // Sticky overflow flag and completed-frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r <= 1'b0;
         frames_r   <= 16'd0;
      end else begin
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
         if (frame_done_s) begin
            frames_r <= frames_r + 16'd1;
         end
      end
   end

   assign uart_wreq   = wreq_r;
   assign uart_wdata  = wdata_r;
   assign overflow    = overflow_r;
   assign frames_sent = frames_r;
   assign busy        = busy_r;

endmodule

// File: doc/adc_uart_packer.md
ADC_UART_PACKER -- requirements
Module: adc_uart_packer

Interface
REQ-001 Parameter NUM_bit, 6, width of one ADC conversion word (1..8).
REQ-002 Parameter FIFO_DEPTH, 16, sample buffer entries (power of two, >=4).
REQ-003 Parameter FRAME_LEN, 256, samples per UART frame (1..65535).
REQ-004 Parameter HEADER, 8'hA5, frame start byte.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  level; permits capture and frame start.
REQ-008 sample_vld  in  1  one-cycle strobe, sample_data valid.
REQ-009 sample_data  in  NUM_bit  ADC conversion result.
REQ-010 uart_rdy  in  1  transmitter idle and able to accept a byte.
REQ-011 uart_wreq  out  1  one-cycle byte write request.
REQ-012 uart_wdata  out  8  byte to transmit, valid with uart_wreq.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-014 overflow  out  1  sticky; a sample was dropped.
REQ-015 frames_sent  out  16  completed-frame counter.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 Buffer SHALL be a FIFO_DEPTH-entry FIFO; push on sample_vld & enable & not full; sample_data zero-extended to 8 bits on push.
REQ-018 sample_vld while full SHALL drop the sample and set overflow; FIFO contents unchanged.
REQ-019 Simultaneous push and pop SHALL leave fifo_level unchanged; push while full with same-cycle pop SHALL be accepted.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.
REQ-021 FSM states: IDLE, HEAD, DATA, CSUM.
REQ-022 IDLE->HEAD when enable=1 and FIFO non-empty; sample counter and checksum cleared.
REQ-023 HEAD: issue HEADER byte, then ->DATA.
REQ-024 DATA: each write pops one FIFO word, sends it, XORs it into checksum, increments sample counter; after the FRAME_LEN-th byte ->CSUM.
REQ-025 DATA with FIFO empty SHALL wait without issuing uart_wreq.
REQ-026 CSUM: issue 8-bit XOR of all FRAME_LEN data bytes, increment frames_sent (wrap at 16'hFFFF->0), ->IDLE.
REQ-027 Deassertion of enable mid-frame SHALL stop new pushes but the current frame SHALL complete as FIFO data permits.
REQ-028 A byte write SHALL occur only when uart_rdy=1 and the cycle is not the one immediately after a uart_wreq (one-cycle blanking, since uart_rdy falls one cycle after wreq).
REQ-029 uart_wreq SHALL be high for exactly one cycle per byte; uart_wdata registered and stable that cycle.
REQ-030 Pop-to-wreq latency SHALL be 1 cycle (registered FIFO read into uart_wdata).

Reset
REQ-031 On rst: state IDLE, FIFO empty, fifo_level 0, uart_wreq 0, uart_wdata 8'h00, overflow 0, frames_sent 0, busy 0, checksum and counters 0.
REQ-032 rst mid-frame SHALL abort immediately; partial frame discarded, no further bytes issued until a new frame starts.
REQ-033 overflow SHALL clear only on rst.

Structure
REQ-034 State encoding and HEADER default SHALL live in a shared package giraffe_pkg.
REQ-035 FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; outputs full, empty, level).
REQ-036 FSM, checksum, counters and UART handshake SHALL reside in adc_uart_packer.

Verification
REQ-037 FRAME_LEN=4, push 6'h01,02,03,04, uart_rdy held 1 -> bytes A5,01,02,03,04,04 in order; frames_sent=1.
REQ-038 Push 17 samples with uart_rdy=0, FIFO_DEPTH=16 -> fifo_level=16, overflow=1, 17th sample never transmitted.
REQ-039 uart_rdy=1 constant -> consecutive uart_wreq pulses separated by >=1 idle cycle; no back-to-back wreq.
REQ-040 FRAME_LEN=4, 2 samples then pause 50 cycles then 2 samples -> no wreq during pause; frame completes with checksum of all 4.
REQ-041 Assert rst after HEADER and 1 data byte -> all outputs at reset values next edge; next frame begins with A5.
REQ-042 Drop enable after HEAD of a 4-sample frame with 4 samples buffered -> full frame plus checksum still sent, then IDLE, busy=0.
